// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search datapath.
//   ptc_state_t : pt_check scan FSM states
//   PRINT_LO/HI : inclusive printable-ASCII window used as pt_check defaults
//   in_range()  : unsigned inclusive window test on one byte
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    WLEN = 3'd2,
    ADDR = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } ptc_state_t;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Unsigned compare: 8'hFF is above HI, never treated as negative.
  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_check.sv
// pt_check: scans a length-prefixed message in pt memory (byte 0 = L,
// bytes 1..L = data) and reports whether every data byte lies in [LO,HI],
// plus the index of the first byte that does not.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   start request, sampled only while rdy=1
//   rdy        out  idle, able to accept en
//   pt_addr    out  pt memory read address
//   pt_rddata  in   pt memory read data, valid one cycle after pt_addr
//   done       out  one-cycle pulse, verdict outputs valid
//   ok         out  all L bytes in range; held until the next accept
//   bad_idx    out  index of first failing byte (0 when ok); held
//   len        out  length byte from address 0; held
//   state_dbg  out  current FSM state, for observation only
//
// Handshake: en/rdy is a plain valid/ready pair. A start transfers on a
// rising edge where en=1 and rdy=1; en is a don't-care whenever rdy=0
// (including the DONE cycle). done is an unconditional one-cycle pulse;
// there is no back-pressure on the verdict.
module pt_check
  import arc4_pkg::*;
#(
  parameter logic [7:0] LO     = PRINT_LO,
  parameter logic [7:0] HI     = PRINT_HI,
  parameter int         ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rddata,
  output logic              done,
  output logic              ok,
  output logic [ADDR_W-1:0] bad_idx,
  output logic [ADDR_W-1:0] len,
  output ptc_state_t        state_dbg
);

  ptc_state_t        state;
  logic [ADDR_W-1:0] i;
  // Last address actually driven; pt_addr holds it outside LEN/ADDR.
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ok      <= 1'b0;
      bad_idx <= '0;
      len     <= '0;
      i       <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            ok      <= 1'b0;
            bad_idx <= '0;
            len     <= '0;
            state   <= LEN;
          end
        end
        LEN: begin
          addr_q <= '0;
          state  <= WLEN;
        end
        WLEN: begin
          len <= ADDR_W'(pt_rddata);
          i   <= ADDR_W'(1);
          if (pt_rddata == 8'h00) begin
            ok    <= 1'b1;
            state <= DONE;
          end else begin
            state <= ADDR;
          end
        end
        ADDR: begin
          addr_q <= i;
          state  <= CHK;
        end
        CHK: begin
          if (!in_range(pt_rddata, LO, HI)) begin
            ok      <= 1'b0;
            bad_idx <= i;
            state   <= DONE;
          end else if (i == len) begin
            // Last byte checked; i is never incremented past len, so
            // L = 2**ADDR_W-1 terminates without wrapping.
            ok    <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + ADDR_W'(1);
            state <= ADDR;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pt_addr = addr_q;
    if (state == LEN)  pt_addr = '0;
    if (state == ADDR) pt_addr = i;
    rdy  = (state == IDLE);
    done = (state == DONE);
  end

  assign state_dbg = state;

endmodule
